// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared constants for the adder result path.
//   CNT_W          width of the saturating event counters (drop / overflow)
//   ENTRY_FLAGS_W  number of flag bits stored next to each sum (cout, ovf)
//   entry_width()  total packed width of one stored result entry
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int CNT_W         = 16;
    localparam int ENTRY_FLAGS_W = 2;

    // Stored entry layout is {sum, cout, ovf}, MSB first.
    function automatic int entry_width(input int data_width);
        return data_width + ENTRY_FLAGS_W;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   clock, rising edge
//   clear  in   synchronous active-high clear (wins over inc)
//   inc    in   count one event this cycle
//   count  out  current count, WIDTH bits
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/adder_result_fifo.sv
// ---------------------------------------------------------------------------
// adder_result_fifo
// First-word-fall-through FIFO that buffers adder results {sum, cout, ovf}.
// The upstream adder cannot be stalled, so a result arriving while the FIFO
// is full (and nothing leaves that cycle) is lost and counted in drop_cnt.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_sum/in_cout/in_ovf result from the adder (no ready)
//   flush                         discard all stored entries
//   out_valid/out_ready           head handshake
//   out_sum/out_cout/out_ovf      head entry fields (zero while empty)
//   full, empty, count            occupancy
//   drop_cnt, ovf_cnt             saturating event counters
//
// Handshake: the head entry is consumed on every rising edge where
// out_valid=1 and out_ready=1; out_valid never depends on out_ready and the
// head fields stay stable while out_valid=1 and out_ready=0.
// ---------------------------------------------------------------------------
module adder_result_fifo
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_sum,
    input  logic                     in_cout,
    input  logic                     in_ovf,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         ovf_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_width(DATA_WIDTH);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    // Pointer wrap relies on DEPTH being a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "adder_result_fifo: DEPTH must be a power of two and >= 2");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] sum;
        logic                  cout;
        logic                  ovf;
    } entry_t;

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    logic   handshake;
    logic   push;
    logic   pop;
    logic   drop;
    entry_t head;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign out_valid = !empty;
    assign count     = count_q;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a
    // push when the head is leaving. Flush overrides both.
    assign handshake = out_valid && out_ready;
    assign pop       = handshake && !flush;
    assign push      = in_valid && (!full || handshake) && !flush;
    assign drop      = in_valid && full && !handshake && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the output mux below hides stale contents.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {in_sum, in_cout, in_ovf};
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign out_sum  = out_valid ? head.sum  : '0;
    assign out_cout = out_valid ? head.cout : 1'b0;
    assign out_ovf  = out_valid ? head.ovf  : 1'b0;

    sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (drop),
        .count (drop_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (push && in_ovf),
        .count (ovf_cnt)
    );

endmodule

// File: tb/tb_adder_result_fifo.sv
module tb_adder_result_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int SAT   = 65535;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DW-1:0]     in_sum;
    logic              in_cout;
    logic              in_ovf;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_sum;
    logic              out_cout;
    logic              out_ovf;
    logic              full;
    logic              empty;
    logic [OCC_W-1:0]  count;
    logic [15:0]       drop_cnt;
    logic [15:0]       ovf_cnt;

    // Expected FIFO contents, entries packed as {sum, cout, ovf}.
    logic [DW+1:0] exp_q[$];
    int drop_m;
    int ovf_m;
    int n_vec;
    int n_err;
    bit mon_en;

    adder_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_ovf    (in_ovf),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .ovf_cnt   (ovf_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; applies inputs for the next edge and
    // updates the reference model for what that edge must do.
    task automatic drive(input logic v, input logic [DW-1:0] s, input logic c, input logic o,
                         input logic rdy, input logic fl, input logic rs);
        int sz;
        bit pop_p, acc, drp;
        rst       = rs;
        flush     = fl;
        in_valid  = v;
        in_sum    = s;
        in_cout   = c;
        in_ovf    = o;
        out_ready = rdy;
        sz    = exp_q.size();
        pop_p = rdy && (sz > 0);
        acc   = v && !fl && !rs && ((sz < DEPTH) || pop_p);
        drp   = v && !fl && !rs && (sz == DEPTH) && !pop_p;
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
            drop_m = 0;
            ovf_m  = 0;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            // the monitor already removed the popped head at the negedge
            if (acc) begin
                exp_q.push_back({s, c, o});
                if (o && ovf_m < SAT) ovf_m++;
            end
            if (drp && drop_m < SAT) drop_m++;
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [DW-1:0] s, input logic o, input logic rdy);
        drive(1'b1, s, 1'b0, o, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("head", 64'({out_sum, out_cout, out_ovf}), 64'(exp_q[0]));
            end
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("full", 64'(full), 64'(exp_q.size() == DEPTH));
            chk("empty", 64'(empty), 64'(exp_q.size() == 0));
            chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
            chk("ovf_cnt", 64'(ovf_cnt), 64'(ovf_m));
            if (exp_q.size() != 0 && out_ready && !flush && !rst) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec  = 0;
        n_err  = 0;
        drop_m = 0;
        ovf_m  = 0;
        mon_en = 1'b0;

        // reset state
        do_reset();
        mon_en = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);

        // single push, visible the next cycle
        push(32'h0000_0005, 1'b0, 1'b0);
        chk("first_sum", 64'(out_sum), 64'd5);
        chk("first_count", 64'(count), 64'd1);
        idle(1'b1);
        idle(1'b0);

        // fill past capacity, then drain in order
        for (int i = 1; i <= 10; i++) push(DW'(i), (i <= 2), 1'b0);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_drop", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("drain_empty", 64'(empty), 64'd1);

        // full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(DW'(32'h50 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push(DW'(32'h100 + i), 1'b0, 1'b1);
            chk("pp_count", 64'(count), 64'd8);
            chk("pp_drop", 64'(drop_cnt), 64'd0);
        end
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        chk("pp_empty", 64'(empty), 64'd1);

        // randomized traffic with alternating consumer speed
        for (int i = 0; i < 3000; i++) begin
            int p_rdy;
            p_rdy = ((i / 200) % 2 == 1) ? 80 : 20;
            drive(($urandom_range(0, 99) < 70), $urandom, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < p_rdy), ($urandom_range(0, 63) == 0), 1'b0);
        end

        // flush with a same-cycle push
        do_reset();
        for (int i = 1; i <= 10; i++) push(DW'(i), (i <= 2), 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("pre_flush_count", 64'(count), 64'd5);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_drop", 64'(drop_cnt), 64'd2);
        chk("flush_ovf", 64'(ovf_cnt), 64'd2);
        idle(1'b0);

        // reset mid-stream
        for (int i = 0; i < 6; i++) push(DW'(32'h600 + i), 1'b1, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd6);
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(out_sum), 64'd0);
        chk("mid_rst_cout", 64'(out_cout), 64'd0);
        chk("mid_rst_ovf", 64'(out_ovf), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_full", 64'(full), 64'd0);
        chk("mid_rst_ovfcnt", 64'(ovf_cnt), 64'd0);
        push(32'h0000_ABCD, 1'b0, 1'b0);
        chk("post_rst_head", 64'(out_sum), 64'h0000_ABCD);
        chk("post_rst_count", 64'(count), 64'd1);

        // counter saturation
        do_reset();
        for (int i = 0; i < 3; i++) push(DW'(32'h700 + i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) push(DW'(32'h800 + i), 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) push($urandom, 1'b1, 1'b0);
        chk("sat_ovf", 64'(ovf_cnt), 64'd3);
        chk("sat_drop", 64'(drop_cnt), 64'hFFFF);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
